branch_hazard_ctrl: RTL and testbench

- Decode-stage hazard controller for the D-stage branch comparator (beq/bne resolved in D).
- Keeps a two-slot shadow scoreboard of in-flight register writers in the E and M stages.
- Decides each cycle whether the comparator's rs/rt operands are ready, forwardable or require a stall.
- Drives the D-stage freeze, the E-stage bubble, the operand-forward selects, and a stall-cycle performance counter.

---
 rtl/branch_hazard_ctrl_if.sv | 29 ++
 rtl/branch_hazard_ctrl.sv | 61 ++++++
 tb/tb_branch_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: D-stage hazard request/response bundle
interface branch_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             validD;
  logic [4:0]       rsAddrD;
  logic [4:0]       rtAddrD;
  logic             useRsD;
  logic             useRtD;
  logic [1:0]       tuseRsD;
  logic [1:0]       tuseRtD;
  logic             regWriteD;
  logic [4:0]       dstAddrD;
  logic [1:0]       tnewD;
  logic             flushReq;
  logic             stallD;
  logic             flushE;
  logic [1:0]       fwdRsD;
  logic [1:0]       fwdRtD;
  logic [CNT_W-1:0] stallCnt;
  modport master (
    output validD, rsAddrD, rtAddrD, useRsD, useRtD, tuseRsD, tuseRtD,
           regWriteD, dstAddrD, tnewD, flushReq,
    input  stallD, flushE, fwdRsD, fwdRtD, stallCnt
  );
  modport slave (
    input  validD, rsAddrD, rtAddrD, useRsD, useRtD, tuseRsD, tuseRtD,
           regWriteD, dstAddrD, tnewD, flushReq,
    output stallD, flushE, fwdRsD, fwdRtD, stallCnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: stall/forward control for the D-stage branch comparator
module branch_hazard_ctrl #(parameter int CNT_W = 32) (
  input logic clk,
  input logic reset,
  branch_hazard_ctrl_if.slave bus
);
  logic             vE, vM;
  logic [4:0]       aE, aM;
  logic [1:0]       tE, tM;
  logic [2:0]       hzRs, hzRt;
  logic             stall;
  logic [CNT_W-1:0] cnt;
  function automatic logic [2:0] hazard(
    input logic act, input logic [4:0] addr, input logic [1:0] tuse,
    input logic ve, input logic [4:0] ae, input logic [1:0] te,
    input logic vm, input logic [4:0] am, input logic [1:0] tm
  );
    logic hitE, hitM;
    hitE = act && ve && ae == addr;
    hitM = act && vm && am == addr;
    return hitE ? {te > tuse, te == 2'd0 ? 2'd2 : 2'd0}
         : hitM ? {tm > tuse, tm == 2'd0 ? 2'd1 : 2'd0}
         : 3'b000;
  endfunction
  // Per-source readiness against the youngest in-flight writer
  always_comb begin
    hzRs = hazard(bus.validD && bus.useRsD && |bus.rsAddrD, bus.rsAddrD, bus.tuseRsD,
                  vE, aE, tE, vM, aM, tM);
    hzRt = hazard(bus.validD && bus.useRtD && |bus.rtAddrD, bus.rtAddrD, bus.tuseRtD,
                  vE, aE, tE, vM, aM, tM);
    stall = hzRs[2] | hzRt[2];
    bus.stallD = stall;
    bus.flushE = stall;
    bus.fwdRsD = stall ? 2'd0 : hzRs[1:0];
    bus.fwdRtD = stall ? 2'd0 : hzRt[1:0];
    bus.stallCnt = cnt;
  end
  // Advance the E/M writer scoreboard; a stall injects a bubble into E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vE <= 1'b0;
      vM <= 1'b0;
      aE <= 5'd0;
      aM <= 5'd0;
      tE <= 2'd0;
      tM <= 2'd0;
    end else begin
      vM <= !bus.flushReq && vE;
      aM <= aE;
      tM <= tE == 2'd0 ? 2'd0 : tE - 2'd1;
      vE <= !bus.flushReq && !stall && bus.validD && bus.regWriteD && |bus.dstAddrD;
      aE <= bus.dstAddrD;
      tE <= bus.tnewD;
    end
  end
  // Saturating count of stall cycles that are not cancelled by a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (stall && !bus.flushReq && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed checks of branch hazard stalls, forwarding and counting
module tb_branch_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  branch_hazard_ctrl_if #(.CNT_W(32)) bus ();
  branch_hazard_ctrl_if #(.CNT_W(4)) bus4 ();
  branch_hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  branch_hazard_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  assign bus4.validD = bus.validD;
  assign bus4.rsAddrD = bus.rsAddrD;
  assign bus4.rtAddrD = bus.rtAddrD;
  assign bus4.useRsD = bus.useRsD;
  assign bus4.useRtD = bus.useRtD;
  assign bus4.tuseRsD = bus.tuseRsD;
  assign bus4.tuseRtD = bus.tuseRtD;
  assign bus4.regWriteD = bus.regWriteD;
  assign bus4.dstAddrD = bus.dstAddrD;
  assign bus4.tnewD = bus.tnewD;
  assign bus4.flushReq = bus.flushReq;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic nextCyc();
    @(posedge clk);
    #2;
  endtask
  task automatic setD(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [1:0] trs,
                      input logic [1:0] trt, input logic w, input logic [4:0] dst,
                      input logic [1:0] tn);
    bus.validD = v;
    bus.rsAddrD = rs;
    bus.rtAddrD = rt;
    bus.useRsD = urs;
    bus.useRtD = urt;
    bus.tuseRsD = trs;
    bus.tuseRtD = trt;
    bus.regWriteD = w;
    bus.dstAddrD = dst;
    bus.tnewD = tn;
  endtask
  task automatic idle();
    setD(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endtask
  task automatic writer(input logic [4:0] dst, input logic [1:0] tn);
    setD(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, dst, tn);
  endtask
  task automatic branch(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt);
    setD(1'b1, rs, rt, 1'b1, 1'b1, trs, trt, 1'b0, 5'd0, 2'd0);
  endtask
  initial begin
    bus.flushReq = 1'b0;
    setD(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    nextCyc(); nextCyc(); nextCyc();
    #1;
    chk("rst_stallD", bus.stallD, 0);
    chk("rst_fwdRs", bus.fwdRsD, 0);
    chk("rst_cnt", bus.stallCnt, 0);
    reset = 1'b0;
    idle();
    nextCyc();
    writer(5'd8, 2'd1); #1;
    chk("alu_wr_stall", bus.stallD, 0);
    nextCyc();
    branch(5'd8, 5'd0, 2'd0, 2'd0); #1;
    chk("alu_beq_stall", bus.stallD, 1);
    chk("alu_beq_flushE", bus.flushE, 1);
    nextCyc(); #1;
    chk("alu_beq_release", bus.stallD, 0);
    chk("alu_beq_fwdRs", bus.fwdRsD, 1);
    chk("alu_beq_cnt", bus.stallCnt, 1);
    nextCyc();
    idle();
    nextCyc();
    writer(5'd9, 2'd2);
    nextCyc();
    branch(5'd0, 5'd9, 2'd0, 2'd0); #1;
    chk("lw_bne_stall1", bus.stallD, 1);
    nextCyc(); #1;
    chk("lw_bne_stall2", bus.stallD, 1);
    chk("lw_bne_fwd0_in_stall", bus.fwdRtD, 0);
    nextCyc(); #1;
    chk("lw_bne_release", bus.stallD, 0);
    chk("lw_bne_fwdRt", bus.fwdRtD, 0);
    chk("lw_bne_cnt", bus.stallCnt, 3);
    idle();
    nextCyc(); nextCyc();
    writer(5'd9, 2'd2);
    nextCyc();
    branch(5'd0, 5'd9, 2'd0, 2'd2); #1;
    chk("lw_late_use_stall", bus.stallD, 0);
    chk("lw_late_use_fwdRt", bus.fwdRtD, 0);
    idle();
    nextCyc(); nextCyc();
    writer(5'd31, 2'd0);
    nextCyc();
    branch(5'd31, 5'd31, 2'd0, 2'd0); #1;
    chk("jal_stall", bus.stallD, 0);
    chk("jal_fwdRsE", bus.fwdRsD, 2);
    chk("jal_fwdRtE", bus.fwdRtD, 2);
    nextCyc(); #1;
    chk("jal_m_stall", bus.stallD, 0);
    chk("jal_fwdRsM", bus.fwdRsD, 1);
    chk("jal_fwdRtM", bus.fwdRtD, 1);
    idle();
    nextCyc(); nextCyc();
    writer(5'd0, 2'd2);
    nextCyc();
    branch(5'd0, 5'd0, 2'd0, 2'd0); #1;
    chk("zero_reg_stall", bus.stallD, 0);
    chk("zero_reg_fwdRs", bus.fwdRsD, 0);
    idle();
    nextCyc(); nextCyc();
    writer(5'd4, 2'd0);
    nextCyc();
    writer(5'd4, 2'd0);
    nextCyc();
    branch(5'd4, 5'd0, 2'd0, 2'd0); #1;
    chk("prio_stall", bus.stallD, 0);
    chk("prio_fwdRs", bus.fwdRsD, 2);
    idle();
    nextCyc(); nextCyc();
    writer(5'd9, 2'd2);
    nextCyc();
    branch(5'd9, 5'd0, 2'd0, 2'd0);
    bus.flushReq = 1'b1; #1;
    chk("flush_stall_before", bus.stallD, 1);
    nextCyc();
    bus.flushReq = 1'b0; #1;
    chk("flush_stall_after", bus.stallD, 0);
    chk("flush_cnt", bus.stallCnt, 3);
    chk("cnt4_before_sat", bus4.stallCnt, 3);
    idle();
    nextCyc();
    for (int i = 0; i < 7; i++) begin
      writer(5'd9, 2'd2);
      nextCyc();
      branch(5'd9, 5'd0, 2'd0, 2'd0);
      nextCyc(); nextCyc();
    end
    idle(); #1;
    chk("cnt32_after_loop", bus.stallCnt, 17);
    chk("cnt4_saturated", bus4.stallCnt, 15);
    nextCyc();
    writer(5'd9, 2'd2);
    nextCyc();
    branch(5'd9, 5'd0, 2'd0, 2'd0); #1;
    chk("midrst_stall_pre", bus.stallD, 1);
    reset = 1'b1; #1;
    chk("midrst_stall_async", bus.stallD, 0);
    chk("midrst_cnt", bus.stallCnt, 0);
    chk("midrst_cnt4", bus4.stallCnt, 0);
    nextCyc();
    reset = 1'b0; #1;
    chk("midrst_release", bus.stallD, 0);
    nextCyc(); #1;
    chk("midrst_no_residual", bus.stallD, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
